// File: rtl/imem_bootloader_if.sv
// Byte-stream input and IMEM write / core-control outputs of the bootloader.
// The master side feeds UART bytes; the slave side is the bootloader itself.
interface imem_bootloader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        imem_write_en;
    logic [31:0] imem_write_data;
    logic [5:0]  imem_write_addr;
    logic        core_start;
    logic        loading;
    logic        load_error;

    modport master (
        output rx_data, rx_valid,
        input  imem_write_en, imem_write_data, imem_write_addr,
        input  core_start, loading, load_error
    );

    modport slave (
        input  rx_data, rx_valid,
        output imem_write_en, imem_write_data, imem_write_addr,
        output core_start, loading, load_error
    );
endinterface

// File: rtl/imem_bootloader.sv
// UART-framed IMEM loader: A5, N, 4*N little-endian payload bytes, XOR checksum,
// then a one-cycle core_start pulse. An inter-byte idle timeout aborts a frame.
//
// state | meaning
// IDLE  | waiting for sync byte 0xA5
// COUNT | waiting for word count N (1..64)
// DATA  | assembling payload words and writing them to IMEM
// CHECK | waiting for checksum byte
// START | one-cycle core_start pulse
module imem_bootloader #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic               clk,
    input  logic               rst,
    imem_bootloader_if.slave   bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMR_RELOAD = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, COUNT, DATA, CHECK, START} state_t;

    state_t        state;
    logic [6:0]    word_cnt;
    logic [5:0]    word_idx;
    logic [1:0]    byte_idx;
    logic [23:0]   asm_word;
    logic [7:0]    csum;
    logic [TW-1:0] idle_tmr;
    logic          in_frame;
    logic          timeout;

    // Down-counter reloaded on every byte; terminal count means TIMEOUT_CYCLES idle cycles elapsed.
    assign in_frame = (state == COUNT) || (state == DATA) || (state == CHECK);
    assign timeout  = in_frame && !bus.rx_valid && (idle_tmr == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            word_cnt            <= '0;
            word_idx            <= '0;
            byte_idx            <= '0;
            asm_word            <= '0;
            csum                <= '0;
            idle_tmr            <= '0;
            bus.imem_write_en   <= 1'b0;
            bus.imem_write_data <= '0;
            bus.imem_write_addr <= '0;
            bus.core_start      <= 1'b0;
            bus.loading         <= 1'b0;
            bus.load_error      <= 1'b0;
        end else begin
            bus.imem_write_en <= 1'b0;
            bus.core_start    <= 1'b0;

            if (bus.rx_valid)
                idle_tmr <= TMR_RELOAD;
            else if (in_frame && idle_tmr != '0)
                idle_tmr <= idle_tmr - 1'b1;

            case (state)
                IDLE: begin
                    if (bus.rx_valid && bus.rx_data == 8'hA5) begin
                        state          <= COUNT;
                        bus.loading    <= 1'b1;
                        bus.load_error <= 1'b0;
                    end
                end
                COUNT: begin
                    if (bus.rx_valid) begin
                        if (bus.rx_data == 8'd0 || bus.rx_data > 8'd64) begin
                            state          <= IDLE;
                            bus.loading    <= 1'b0;
                            bus.load_error <= 1'b1;
                        end else begin
                            word_cnt <= bus.rx_data[6:0];
                            csum     <= bus.rx_data;
                            word_idx <= '0;
                            byte_idx <= '0;
                            state    <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (bus.rx_valid) begin
                        csum     <= csum ^ bus.rx_data;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: asm_word[7:0]   <= bus.rx_data;
                            2'd1: asm_word[15:8]  <= bus.rx_data;
                            2'd2: asm_word[23:16] <= bus.rx_data;
                            default: begin
                                bus.imem_write_en   <= 1'b1;
                                bus.imem_write_data <= {bus.rx_data, asm_word};
                                bus.imem_write_addr <= word_idx;
                                // Hold the index on the last word so it cannot wrap past 63.
                                if ({1'b0, word_idx} == word_cnt - 7'd1)
                                    state <= CHECK;
                                else
                                    word_idx <= word_idx + 6'd1;
                            end
                        endcase
                    end
                end
                CHECK: begin
                    if (bus.rx_valid) begin
                        if (bus.rx_data == csum) begin
                            state          <= START;
                            bus.core_start <= 1'b1;
                        end else begin
                            state          <= IDLE;
                            bus.loading    <= 1'b0;
                            bus.load_error <= 1'b1;
                        end
                    end
                end
                START: begin
                    state       <= IDLE;
                    bus.loading <= 1'b0;
                end
                default: state <= IDLE;
            endcase

            // Timeout only fires on a cycle without rx_valid, so a late byte always wins.
            if (timeout) begin
                state          <= IDLE;
                bus.loading    <= 1'b0;
                bus.load_error <= 1'b1;
            end
        end
    end
endmodule
